// File: rtl/loader_pkg.sv
// Shared state and file-type definitions for the download sequencer and its write buffer.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        PATCH_LO,
        PATCH_HI,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        FT_ROM,
        FT_PRG,
        FT_IGNORED
    } ftype_t;

    localparam logic [7:0] IDX_ROM     = 8'h00;
    localparam logic [7:0] IDX_PRG     = 8'h01;
    localparam logic [7:0] IDX_PRG_ALT = 8'h41;

    function automatic ftype_t classify(input logic [7:0] idx);
        ftype_t ft;
        case (idx)
            IDX_ROM:              ft = FT_ROM;
            IDX_PRG, IDX_PRG_ALT: ft = FT_PRG;
            default:              ft = FT_IGNORED;
        endcase
        return ft;
    endfunction

endpackage

// File: rtl/loader_wbuf.sv
// One-entry write holding register: presents wr/addr/data until the memory accepts,
// and can take a new entry on the very cycle the pending one is accepted.
module loader_wbuf #(
    parameter int ADDR_W = 25
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              mem_ready,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic              accept,
    output logic              can_load
);

    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    assign accept   = wr_q & mem_ready;
    assign can_load = ~wr_q | mem_ready;

    always_comb begin
        wr_d   = wr_q;
        addr_d = addr_q;
        data_d = data_q;
        if (flush) begin
            wr_d = 1'b0;
        end else if (load && can_load) begin
            wr_d   = 1'b1;
            addr_d = load_addr;
            data_d = load_data;
        end else if (accept) begin
            wr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign wr   = wr_q;
    assign addr = addr_q;
    assign data = data_q;

endmodule

// File: rtl/download_sequencer.sv
// Streams downloaded file bytes into memory and, for PRG files, patches pointer words
// with the end-of-program CPU address. Optional cpu_reset output: LOADER_CPU_RESET_EN.
module download_sequencer
    import loader_pkg::*;
#(
    parameter int                ADDR_W       = 25,
    parameter logic [ADDR_W-1:0] PRG_BASE     = 25'h10995,
    parameter logic [15:0]       PRG_CPU_ADDR = 16'h8995,
    parameter logic [ADDR_W-1:0] PTR_BASE     = 25'h103E9,
    parameter int                NPTR         = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dl_active,
    input  logic [7:0]        dl_index,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              mem_ready,
    output logic              downloading,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic [ADDR_W-1:0] byte_count,
    output logic              overflow
`ifdef LOADER_CPU_RESET_EN
    ,
    output logic              cpu_reset
`endif
);

    localparam logic [1:0] LAST_PTR = 2'(NPTR - 1);

    state_t            state_q, state_d;
    ftype_t            ftype_q, ftype_d;
    logic [ADDR_W-1:0] byte_count_q, byte_count_d;
    logic              overflow_q, overflow_d;
    logic              active_q;
    logic              armed_q, armed_d;
    logic [1:0]        ptr_idx_q, ptr_idx_d;
    logic              patch_last_q, patch_last_d;

    logic              rise;
    logic [15:0]       ptr_val;
    logic [ADDR_W-1:0] ptr_addr;
    logic [ADDR_W-1:0] stream_addr;

    logic              wb_flush, wb_load, wb_accept, wb_can_load;
    logic [ADDR_W-1:0] wb_addr;
    logic [7:0]        wb_data;

    // A download only counts once dl_active has been seen low since reset.
    assign armed_d     = armed_q | ~dl_active;
    assign rise        = dl_active & ~active_q & armed_q;
    assign ptr_val     = PRG_CPU_ADDR + byte_count_q[15:0];
    assign ptr_addr    = PTR_BASE + ADDR_W'({ptr_idx_q, 1'b0});
    assign stream_addr = (ftype_q == FT_PRG) ? PRG_BASE + dl_addr : dl_addr;

    loader_wbuf #(.ADDR_W(ADDR_W)) u_wbuf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (wb_flush),
        .load      (wb_load),
        .load_addr (wb_addr),
        .load_data (wb_data),
        .mem_ready (mem_ready),
        .wr        (wr),
        .addr      (addr),
        .data      (data),
        .accept    (wb_accept),
        .can_load  (wb_can_load)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ftype_q      <= FT_IGNORED;
            byte_count_q <= '0;
            overflow_q   <= 1'b0;
            active_q     <= 1'b0;
            armed_q      <= 1'b0;
            ptr_idx_q    <= '0;
            patch_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ftype_q      <= ftype_d;
            byte_count_q <= byte_count_d;
            overflow_q   <= overflow_d;
            active_q     <= dl_active;
            armed_q      <= armed_d;
            ptr_idx_q    <= ptr_idx_d;
            patch_last_q <= patch_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (rise) state_d = STREAM;
            // Leave only once the holding register has drained.
            STREAM:   if (!dl_active && !wr) state_d = (ftype_q == FT_PRG) ? PATCH_LO : DONE;
            PATCH_LO: begin
                if (rise)             state_d = STREAM;
                else if (wb_can_load) state_d = PATCH_HI;
            end
            PATCH_HI: begin
                if (rise) begin
                    state_d = STREAM;
                end else if (patch_last_q) begin
                    if (!wr) state_d = DONE;
                end else if (wb_can_load && ptr_idx_q != LAST_PTR) begin
                    state_d = PATCH_LO;
                end
            end
            DONE:     state_d = rise ? STREAM : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        ftype_d      = ftype_q;
        byte_count_d = byte_count_q;
        overflow_d   = overflow_q;
        ptr_idx_d    = ptr_idx_q;
        patch_last_d = patch_last_q;
        wb_flush     = 1'b0;
        wb_load      = 1'b0;
        wb_addr      = stream_addr;
        wb_data      = dl_data;
        downloading  = (state_q == STREAM) || (state_q == PATCH_LO) || (state_q == PATCH_HI);

        if (rise && state_q != STREAM) begin
            ftype_d      = classify(dl_index);
            byte_count_d = '0;
            overflow_d   = 1'b0;
            ptr_idx_d    = '0;
            patch_last_d = 1'b0;
            wb_flush     = 1'b1;
        end else begin
            case (state_q)
                STREAM: begin
                    if (wb_accept) byte_count_d = byte_count_q + ADDR_W'(1);
                    if (dl_active && dl_wr && ftype_q != FT_IGNORED) begin
                        if (wb_can_load) wb_load = 1'b1;
                        else             overflow_d = 1'b1;
                    end
                end
                PATCH_LO: begin
                    wb_addr = ptr_addr;
                    wb_data = ptr_val[7:0];
                    wb_load = 1'b1;
                end
                PATCH_HI: begin
                    if (!patch_last_q) begin
                        wb_addr = ptr_addr + ADDR_W'(1);
                        wb_data = ptr_val[15:8];
                        wb_load = 1'b1;
                        if (wb_can_load) begin
                            if (ptr_idx_q == LAST_PTR) patch_last_d = 1'b1;
                            else                       ptr_idx_d = ptr_idx_q + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_count = byte_count_q;
    assign overflow   = overflow_q;

`ifdef LOADER_CPU_RESET_EN
    logic       cpu_reset_q, cpu_reset_d;
    logic [4:0] hold_cnt_q, hold_cnt_d;

    // Held from STREAM entry through DONE, then released 16 cycles later.
    always_comb begin
        cpu_reset_d = cpu_reset_q;
        hold_cnt_d  = hold_cnt_q;
        if (state_d == STREAM && state_q != STREAM) begin
            cpu_reset_d = 1'b1;
            hold_cnt_d  = '0;
        end else if (state_q == DONE) begin
            cpu_reset_d = 1'b1;
            hold_cnt_d  = 5'd16;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - 5'd1;
            if (hold_cnt_q == 5'd1) cpu_reset_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_reset_q <= 1'b1;
            hold_cnt_q  <= 5'd16;
        end else begin
            cpu_reset_q <= cpu_reset_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign cpu_reset = cpu_reset_q;
`endif

endmodule

// File: tb/tb_download_sequencer.sv
// Scoreboard bench for download_sequencer: a default instance (NPTR=1) and an NPTR=3
// instance share stimulus; a monitor pops expected writes as the memory accepts them.
module tb_download_sequencer;

    typedef struct packed {
        logic [24:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic        dl_active;
    logic [7:0]  dl_index;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        mem_ready;

    logic        downloading1, wr1, overflow1;
    logic [24:0] addr1, byte_count1;
    logic [7:0]  data1;
    logic        downloading3, wr3, overflow3;
    logic [24:0] addr3, byte_count3;
    logic [7:0]  data3;

    int          checks = 0;
    int          errors = 0;
    int          mr_mode = 0;
    int          stall = 0;
    wr_t         exp_q[2][$];
    logic        held[2];
    logic [24:0] hold_addr[2];
    logic [7:0]  hold_data[2];

    download_sequencer dut1 (
        .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_index(dl_index),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .mem_ready(mem_ready),
        .downloading(downloading1), .wr(wr1), .addr(addr1), .data(data1),
        .byte_count(byte_count1), .overflow(overflow1)
    );

    download_sequencer #(.NPTR(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_index(dl_index),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .mem_ready(mem_ready),
        .downloading(downloading3), .wr(wr3), .addr(addr3), .data(data3),
        .byte_count(byte_count3), .overflow(overflow3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic pushExp(input int p, input logic [24:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q[p].push_back(e);
    endtask

    task automatic expectStream(input logic [24:0] a, input logic [7:0] d);
        pushExp(0, a, d);
        pushExp(1, a, d);
    endtask

    // Pointer value is the CPU address just past the last program byte.
    task automatic expectPatches(input int nbytes);
        logic [15:0] v;
        v = 16'h8995 + 16'(nbytes);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < ((p == 0) ? 1 : 3); k++) begin
                pushExp(p, 25'h103E9 + 25'(2 * k), v[7:0]);
                pushExp(p, 25'h103E9 + 25'(2 * k + 1), v[15:8]);
            end
        end
    endtask

    task automatic monitorPort(input int p, input logic w, input logic [24:0] a, input logic [7:0] d);
        wr_t e;
        if (held[p]) begin
            checkOutput($sformatf("hold_wr%0d", p), {31'd0, w}, 32'd1);
            checkOutput($sformatf("hold_addr%0d", p), {7'd0, a}, {7'd0, hold_addr[p]});
            checkOutput($sformatf("hold_data%0d", p), {24'd0, d}, {24'd0, hold_data[p]});
        end
        held[p]      = w && !mem_ready;
        hold_addr[p] = a;
        hold_data[p] = d;
        if (w && mem_ready) begin
            if (exp_q[p].size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write%0d: got addr 0x%0h data 0x%0h, required no write", p, a, d);
            end else begin
                e = exp_q[p].pop_front();
                checkOutput($sformatf("wr_addr%0d", p), {7'd0, a}, {7'd0, e.addr});
                checkOutput($sformatf("wr_data%0d", p), {24'd0, d}, {24'd0, e.data});
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            monitorPort(0, wr1, addr1, data1);
            monitorPort(1, wr3, addr3, data3);
        end else begin
            held[0] = 1'b0;
            held[1] = 1'b0;
        end
    end

    // Memory model: always ready, never ready, or two wait cycles per write.
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (mr_mode == 0) begin
                mem_ready = 1'b1;
                stall = 0;
            end else if (mr_mode == 2) begin
                mem_ready = 1'b0;
                stall = 0;
            end else if (wr1 && stall < 2) begin
                mem_ready = 1'b0;
                stall++;
            end else begin
                mem_ready = 1'b1;
                stall = 0;
            end
        end
    end

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic startFile(input logic [7:0] idx);
        dl_index  = idx;
        dl_active = 1'b1;
        applyStimulus();
    endtask

    task automatic sendByte(input logic [24:0] a, input logic [7:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        applyStimulus();
        dl_wr = 1'b0;
    endtask

    task automatic waitWrIdle(input string name);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (!wr1) begin
                ok = 1;
                break;
            end
            applyStimulus();
        end
        checkOutput(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic endFileAndWait(input string name);
        bit ok = 0;
        dl_active = 1'b0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus();
            if (!downloading1 && !downloading3) begin
                ok = 1;
                break;
            end
        end
        checkOutput(name, {31'd0, ok}, 32'd1);
        applyStimulus();
        checkOutput({name, "_q1_empty"}, exp_q[0].size(), 32'd0);
        checkOutput({name, "_q3_empty"}, exp_q[1].size(), 32'd0);
    endtask

    initial begin
        int cnt;
        reset_n   = 1'b0;
        dl_active = 1'b0;
        dl_index  = 8'h00;
        dl_wr     = 1'b0;
        dl_addr   = '0;
        dl_data   = '0;
        held[0]   = 1'b0;
        held[1]   = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("rst_downloading", {31'd0, downloading1}, 32'd0);
        checkOutput("rst_wr", {31'd0, wr1}, 32'd0);
        checkOutput("rst_byte_count", {7'd0, byte_count1}, 32'd0);
        checkOutput("rst_overflow", {31'd0, overflow1}, 32'd0);
        reset_n = 1'b1;
        repeat (2) applyStimulus();

        $display("[TB] PRG of 3 bytes, back-to-back strobes, memory always ready");
        startFile(8'h01);
        expectStream(25'h10995, 8'h11);
        expectStream(25'h10996, 8'h22);
        expectStream(25'h10997, 8'h33);
        expectPatches(3);
        sendByte(25'd0, 8'h11);
        sendByte(25'd1, 8'h22);
        sendByte(25'd2, 8'h33);
        endFileAndWait("prg3_done");
        checkOutput("prg3_byte_count1", {7'd0, byte_count1}, 32'd3);
        checkOutput("prg3_byte_count3", {7'd0, byte_count3}, 32'd3);
        checkOutput("prg3_overflow", {31'd0, overflow1}, 32'd0);

        $display("[TB] ROM of 4 bytes, two wait cycles per write");
        mr_mode = 1;
        startFile(8'h00);
        for (int i = 0; i < 4; i++) begin
            expectStream(25'(i), 8'hA0 + 8'(i));
            sendByte(25'(i), 8'hA0 + 8'(i));
            waitWrIdle($sformatf("rom_drain%0d", i));
        end
        endFileAndWait("rom_done");
        checkOutput("rom_byte_count", {7'd0, byte_count1}, 32'd4);
        checkOutput("rom_overflow", {31'd0, overflow1}, 32'd0);
        mr_mode = 0;

        $display("[TB] second strobe while write pending is dropped");
        mr_mode = 2;
        applyStimulus();
        startFile(8'h00);
        expectStream(25'h10, 8'h5A);
        sendByte(25'h10, 8'h5A);
        sendByte(25'h11, 8'hA5);
        applyStimulus();
        checkOutput("drop_overflow", {31'd0, overflow1}, 32'd1);
        checkOutput("drop_byte_count", {7'd0, byte_count1}, 32'd0);
        checkOutput("drop_pending_addr", {7'd0, addr1}, 32'h10);
        mr_mode = 0;
        repeat (2) applyStimulus();
        checkOutput("drop_byte_count_after", {7'd0, byte_count1}, 32'd1);
        endFileAndWait("drop_done");
        checkOutput("drop_overflow_sticky", {31'd0, overflow1}, 32'd1);

        $display("[TB] empty PRG (alternate index)");
        startFile(8'h41);
        expectPatches(0);
        endFileAndWait("empty_done");
        checkOutput("empty_byte_count", {7'd0, byte_count3}, 32'd0);
        checkOutput("empty_overflow_cleared", {31'd0, overflow1}, 32'd0);

        $display("[TB] ignored file type");
        startFile(8'h07);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            sendByte(25'(i), 8'hC0 + 8'(i));
            if (wr1 || wr3) cnt++;
        end
        checkOutput("ign_downloading", {31'd0, downloading1}, 32'd1);
        endFileAndWait("ign_done");
        checkOutput("ign_wr_cycles", cnt, 32'd0);
        checkOutput("ign_byte_count", {7'd0, byte_count1}, 32'd0);

        $display("[TB] reset during pointer patch");
        mr_mode = 2;
        applyStimulus();
        startFile(8'h01);
        dl_active = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("patch_wr_pending", {31'd0, wr1}, 32'd1);
        checkOutput("patch_lo_addr", {7'd0, addr1}, 32'h103E9);
        checkOutput("patch_lo_data", {24'd0, data1}, 32'h95);
        dl_active = 1'b1;
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_wr", {31'd0, wr1}, 32'd0);
        checkOutput("async_rst_downloading", {31'd0, downloading1}, 32'd0);
        checkOutput("async_rst_addr", {7'd0, addr1}, 32'd0);
        checkOutput("async_rst_data", {24'd0, data1}, 32'd0);
        checkOutput("async_rst_byte_count", {7'd0, byte_count1}, 32'd0);
        checkOutput("async_rst_wr3", {31'd0, wr3}, 32'd0);
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (3) applyStimulus();
        reset_n = 1'b1;
        mr_mode = 0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            if (wr1 || wr3 || downloading1 || downloading3) cnt++;
        end
        checkOutput("post_rst_quiet", cnt, 32'd0);
        dl_active = 1'b0;
        applyStimulus();
        startFile(8'h00);
        expectStream(25'h5, 8'h77);
        sendByte(25'h5, 8'h77);
        endFileAndWait("recover_done");
        checkOutput("recover_byte_count", {7'd0, byte_count1}, 32'd1);

        repeat (3) applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
